// File: rtl/harp_pkg.sv
// Shared types and constants for the string event detector slice.
package harp_pkg;

    localparam int NUM_STRINGS = 8;
    localparam int EVT_ON_BIT  = 7;
    localparam int EVT_STR_LSB = 0;

    typedef logic [7:0] event_t;

    typedef enum logic {
        STR_OFF = 1'b0,
        STR_ON  = 1'b1
    } string_state_t;

    function automatic event_t make_event(input logic on, input logic [2:0] str);
        event_t e;
        e = '0;
        e[EVT_ON_BIT] = on;
        e[EVT_STR_LSB +: 3] = str;
        return e;
    endfunction

endpackage

// File: rtl/string_event_detector_if.sv
// Sample input bus and event output bus of the string event detector.
interface string_event_detector_if;
    import harp_pkg::*;

    logic         sample_valid;
    logic [2:0]   sample_string;
    logic [7:0]   sample_value;
    logic         event_pop;
    logic         event_valid;
    event_t       event_data;
    logic [3:0]   event_count;

    modport master (
        output sample_valid, sample_string, sample_value, event_pop,
        input  event_valid, event_data, event_count
    );

    modport slave (
        input  sample_valid, sample_string, sample_value, event_pop,
        output event_valid, event_data, event_count
    );

endinterface

// File: rtl/string_event_detector_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; output reads zero when empty.
module event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/string_event_detector.sv
// Per-string hysteresis/debounce detector producing note-on/off events into a FIFO.
module string_event_detector
    import harp_pkg::*;
#(
    parameter int           NUM_STRINGS = harp_pkg::NUM_STRINGS,
    parameter logic [7:0]   ON_THRESH   = 8'd160,
    parameter logic [7:0]   OFF_THRESH  = 8'd120,
    parameter int           DEBOUNCE    = 2,
    parameter int           FIFO_DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    string_event_detector_if.slave  bus,
    output logic [7:0]              string_state,
    output logic                    overflow
);

    localparam logic [2:0] DB = 3'(DEBOUNCE);

    string_state_t state_q [NUM_STRINGS];
    string_state_t state_d [NUM_STRINGS];
    logic [2:0]    cnt_q   [NUM_STRINGS];
    logic [2:0]    cnt_d   [NUM_STRINGS];

    logic          push;
    event_t        push_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [2:0]    s;
    logic [2:0]    inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_STRINGS; i++) begin
                state_q[i] <= STR_OFF;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the addressed string moves; every other entry keeps its value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        push      = 1'b0;
        push_data = '0;
        s         = bus.sample_string;
        inc       = cnt_q[s] + 1'b1;
        if (bus.sample_valid) begin
            if (state_q[s] == STR_OFF) begin
                if (bus.sample_value >= ON_THRESH) begin
                    if (inc == DB) begin
                        state_d[s] = STR_ON;
                        cnt_d[s]   = '0;
                        push       = 1'b1;
                        push_data  = make_event(1'b1, s);
                    end else begin
                        cnt_d[s] = inc;
                    end
                end else begin
                    cnt_d[s] = '0;
                end
            end else begin
                if (bus.sample_value <= OFF_THRESH) begin
                    if (inc == DB) begin
                        state_d[s] = STR_OFF;
                        cnt_d[s]   = '0;
                        push       = 1'b1;
                        push_data  = make_event(1'b0, s);
                    end else begin
                        cnt_d[s] = inc;
                    end
                end else begin
                    cnt_d[s] = '0;
                end
            end
        end
    end

    always_comb begin
        string_state = '0;
        for (int unsigned i = 0; i < NUM_STRINGS; i++) begin
            string_state[i] = (state_q[i] == STR_ON);
        end
    end

    event_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_data),
        .pop   (bus.event_pop),
        .dout  (bus.event_data),
        .count (bus.event_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.event_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (push && fifo_full && !bus.event_pop)
            overflow <= 1'b1;
    end

endmodule

// File: tb/tb_string_event_detector.sv
// Directed self-checking bench for string_event_detector with default parameters.
module tb_string_event_detector;

    logic       clk;
    logic       reset;
    logic [7:0] string_state;
    logic       overflow;
    int         tests;
    int         fails;

    string_event_detector_if bus ();

    string_event_detector #(
        .NUM_STRINGS (8),
        .ON_THRESH   (8'd160),
        .OFF_THRESH  (8'd120),
        .DEBOUNCE    (2),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .string_state (string_state),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [2:0] str, input logic [7:0] val, input logic pop);
        bus.sample_valid  = 1'b1;
        bus.sample_string = str;
        bus.sample_value  = val;
        bus.event_pop     = pop;
        tick();
        bus.sample_valid  = 1'b0;
        bus.event_pop     = 1'b0;
    endtask

    task automatic pop1();
        bus.event_pop = 1'b1;
        tick();
        bus.event_pop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_fifo(input string tag, input logic [7:0] data, input logic [7:0] cnt);
        chk({tag, "_data"}, bus.event_data, data);
        chk({tag, "_count"}, 8'(bus.event_count), cnt);
        chk({tag, "_valid"}, 8'(bus.event_valid), (cnt != 8'd0) ? 8'd1 : 8'd0);
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        bus.sample_valid  = 1'b0;
        bus.sample_string = '0;
        bus.sample_value  = '0;
        bus.event_pop     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk_fifo("reset", 8'h00, 8'd0);
        chk("reset_state", string_state, 8'h00);
        chk("reset_ovf", 8'(overflow), 8'd0);

        // string 3 on after two qualifying samples
        sample(3'd3, 8'd200, 1'b0);
        chk("s3_on1_state", string_state, 8'h00);
        chk_fifo("s3_on1", 8'h00, 8'd0);
        sample(3'd3, 8'd200, 1'b0);
        chk("s3_on2_state", string_state, 8'h08);
        chk_fifo("s3_on2", 8'h83, 8'd1);

        // in-band value clears the off debounce
        sample(3'd3, 8'd100, 1'b0);
        sample(3'd3, 8'd130, 1'b0);
        chk("s3_band_state", string_state, 8'h08);
        chk_fifo("s3_band", 8'h83, 8'd1);
        sample(3'd3, 8'd100, 1'b0);
        chk("s3_off1_state", string_state, 8'h08);
        chk_fifo("s3_off1", 8'h83, 8'd1);
        sample(3'd3, 8'd100, 1'b0);
        chk("s3_off2_state", string_state, 8'h00);
        chk_fifo("s3_off2", 8'h83, 8'd2);
        pop1();
        chk_fifo("pop_a", 8'h03, 8'd1);
        pop1();
        chk_fifo("pop_b", 8'h00, 8'd0);
        pop1();
        chk_fifo("pop_empty", 8'h00, 8'd0);

        // thresholds are inclusive: 159 does not count, 160 does
        sample(3'd4, 8'd159, 1'b0);
        sample(3'd4, 8'd160, 1'b0);
        chk("thr_edge_state", string_state, 8'h00);
        sample(3'd4, 8'd160, 1'b0);
        chk("thr_on_state", string_state, 8'h10);
        sample(3'd4, 8'd121, 1'b0);
        sample(3'd4, 8'd120, 1'b0);
        chk("thr_off_edge", string_state, 8'h10);
        sample(3'd4, 8'd120, 1'b0);
        chk("thr_off_state", string_state, 8'h00);
        chk_fifo("thr_fifo", 8'h84, 8'd2);
        pop1();
        pop1();
        chk_fifo("thr_drained", 8'h00, 8'd0);

        // interleaved strings 0 and 1
        sample(3'd0, 8'd200, 1'b0);
        sample(3'd1, 8'd200, 1'b0);
        sample(3'd0, 8'd200, 1'b0);
        chk("alt_s0_state", string_state, 8'h01);
        sample(3'd1, 8'd200, 1'b0);
        chk("alt_s1_state", string_state, 8'h03);
        chk_fifo("alt_head", 8'h80, 8'd2);
        pop1();
        chk_fifo("alt_second", 8'h81, 8'd1);
        pop1();
        chk_fifo("alt_empty", 8'h00, 8'd0);

        // fill FIFO: strings 2..7 on, then 0 and 1 off
        for (int i = 2; i < 8; i++) begin
            sample(3'(i), 8'd200, 1'b0);
            sample(3'(i), 8'd200, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            sample(3'(i), 8'd50, 1'b0);
            sample(3'(i), 8'd50, 1'b0);
        end
        chk("full_state", string_state, 8'hFC);
        chk_fifo("full", 8'h82, 8'd8);
        chk("full_ovf", 8'(overflow), 8'd0);

        // push and pop together while full
        sample(3'd2, 8'd50, 1'b0);
        sample(3'd2, 8'd50, 1'b1);
        chk("pushpop_state", string_state, 8'hF8);
        chk_fifo("pushpop", 8'h83, 8'd8);
        chk("pushpop_ovf", 8'(overflow), 8'd0);

        // push while full with no pop drops the event
        sample(3'd3, 8'd50, 1'b0);
        sample(3'd3, 8'd50, 1'b0);
        chk("drop_state", string_state, 8'hF0);
        chk_fifo("drop", 8'h83, 8'd8);
        chk("drop_ovf", 8'(overflow), 8'd1);

        drain_exp[0] = 8'h83; drain_exp[1] = 8'h84; drain_exp[2] = 8'h85; drain_exp[3] = 8'h86;
        drain_exp[4] = 8'h87; drain_exp[5] = 8'h00; drain_exp[6] = 8'h01; drain_exp[7] = 8'h02;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), bus.event_data, drain_exp[i]);
            pop1();
        end
        chk_fifo("drained", 8'h00, 8'd0);
        chk("drained_ovf", 8'(overflow), 8'd1);

        // reset mid-debounce with a queued event
        sample(3'd5, 8'd50, 1'b0);
        sample(3'd5, 8'd50, 1'b0);
        chk_fifo("pre_reset", 8'h05, 8'd1);
        sample(3'd0, 8'd200, 1'b0);
        do_reset();
        chk_fifo("post_reset", 8'h00, 8'd0);
        chk("post_reset_state", string_state, 8'h00);
        chk("post_reset_ovf", 8'(overflow), 8'd0);
        sample(3'd0, 8'd200, 1'b0);
        chk("post_reset_s0", string_state, 8'h00);
        chk_fifo("post_reset_s0", 8'h00, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/string_event_detector.md
# string_event_detector

Turns per-string ADC light readings into note-on/note-off events. Each string has hysteresis thresholds and sample-count debounce. Detected events are queued in a small show-ahead FIFO for the Raspberry Pi SPI slave to drain. The block sits downstream of the string-update/ADC-reader path, which supplies one sample per string per mirror step, and upstream of the Pi interface.

## Interface
Parameters:
- NUM_STRINGS, 8, number of strings; the string index is 3 bits.
- ON_THRESH, 8'd160, a sample >= this value counts toward note-on.
- OFF_THRESH, 8'd120, a sample <= this value counts toward note-off. Must be < ON_THRESH.
- DEBOUNCE, 2, consecutive qualifying samples required to change state. Range 1..7.
- FIFO_DEPTH, 8, event queue entries. Power of two.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  one-cycle strobe; sample_string/sample_value valid.
- sample_string  in  3  string index of the sample.
- sample_value  in  8  ADC reading (upper 8 bits).
- event_pop  in  1  consumer removes the head event this cycle.
- event_valid  out  1  FIFO not empty.
- event_data  out  8  head event {on, 4'b0000, string[2:0]}; 8'h00 when empty.
- event_count  out  4  FIFO occupancy, 0..FIFO_DEPTH.
- string_state  out  8  bit i = 1 while string i is sounding.
- overflow  out  1  sticky; an event was dropped.

## Operation
- Per-string state: a sounding bit plus a 3-bit debounce counter.
- On sample_valid, string s = sample_string is updated:
  - State OFF, value >= ON_THRESH: counter increments. When the incremented value equals DEBOUNCE, the string goes ON, the counter clears, and the on-event {1,0000,s} is pushed.
  - State OFF, value < ON_THRESH: counter clears.
  - State ON, value <= OFF_THRESH: same counting. On reaching DEBOUNCE the string goes OFF and the off-event {0,0000,s} is pushed.
  - State ON, value > OFF_THRESH: counter clears.
  - A value between the thresholds clears the counter in either state.
- Only string s changes on a given sample. All other strings hold state and counter.
- DEBOUNCE=1 gives an immediate transition on the first qualifying sample.
- FIFO behaviour:
  - Show-ahead: event_data is the oldest entry.
  - Pop while empty is ignored.
  - Push with no pop while full: the event is dropped and overflow sets. The string state transition still occurs.
  - Simultaneous push and pop while full: both happen and the count is unchanged.
  - Simultaneous push and pop while empty: the pop is ignored and the push is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow clears only on reset.

## Timing
- Reset values:
  - All strings OFF, all counters 0.
  - FIFO empty.
  - event_valid=0, event_data=8'h00, event_count=0, string_state=8'h00, overflow=0.
- A sample_valid in cycle N updates string_state in cycle N+1.
- A resulting push is visible as event_valid/event_data in N+1 if the FIFO was empty. Otherwise it appears behind the existing entries.
- A pop in cycle N advances the head in N+1, and event_count decrements in N+1.
- sample_valid may be asserted every cycle, including back-to-back samples on the same string. Each sample is counted.
- Reset asserted mid-debounce or with the FIFO non-empty discards everything on the next edge and emits no events.

## Structure
- Package harp_pkg holds:
  - NUM_STRINGS and the event bit positions: EVT_ON_BIT=7, EVT_STR_LSB=0.
  - A typedef for the 8-bit event word.
  - The enum string_state_t {STR_OFF, STR_ON}.
- Sub-module event_fifo: parameterised width/depth synchronous FIFO with show-ahead output, count and full/empty.
- The detector core instantiates event_fifo once.
- Per-string registers are arrays indexed by sample_string. There is no per-string instance.

## Test plan
- Reset, then samples 200,200 on string 3 (DEBOUNCE=2): string_state=8'h08 after the second sample; event_data=8'h83, event_count=1.
- String 3 ON, samples 100,130,100,100: no event after the 130. The off-event 8'h03 appears only after the fourth sample.
- Alternating strings 0 and 1 at 200 every cycle: both go ON after their second samples; FIFO order is 8'h80 then 8'h81.
- Nine on/off transitions with no pops: event_count saturates at 8, overflow=1, and string_state still reflects all transitions. Popping then yields the first eight events in order.
- FIFO full with a push and pop in the same cycle: event_count stays 8 and overflow stays 0.
- Reset asserted one sample into a debounce: the next single sample of 200 produces no event.
